// File: rtl/sid_filters_mc.sv
// ---------------------------------------------------------------------------
// sid_filters_mc
//   Time-multiplexed, multi-channel SID state-variable filter and output
//   mixer. One frame carries one sample per SID. The frame is captured on
//   in_valid & in_ready, and the channels are then processed in order
//   0..CHANNELS-1 through one shared multiplier. Each channel keeps its own
//   integrator state (Vhp/Vbp/Vlp) from one frame to the next.
//
//   Per-channel schedule:
//     MIX1..MIX4, then ITERS x (SVF1..SVF4), then FSUM, then VOL.
//   That is 6 + 4*ITERS cycles per channel. After the last channel a
//   single DONE cycle raises out_valid, and the FSM then returns to IDLE.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   in_valid       frame start, accepted only while in_ready=1
//   in_ready       high while the block is idle
//   f0             per-channel cutoff coefficient w0 (unsigned, MSB 0)
//   res_filt       per-channel [7:4] resonance, [3:0] route ext,v3,v2,v1
//   mode_vol       per-channel [7] v3off, [6] HP, [5] BP, [4] LP, [3:0] vol
//   voice1/2/3     per-channel signed voice samples
//   ext_in         per-channel signed external input
//   enable         0: output mixes the filter input Vi instead of Vf
//   mode           1: Vf unscaled, 0: Vf - (Vf >>> 2)
//   mixctl         [1] mute unfiltered path, [0] mute filtered path
//   sound          per-channel signed output lanes, registered
//   out_valid      one-cycle pulse when all sound lanes have been updated
// ---------------------------------------------------------------------------
module sid_filters_mc #(
  parameter int CHANNELS  = 2,
  parameter int DW        = 18,
  parameter int ITERS     = 1,
  parameter int DC_OFFSET = 16384
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CHANNELS*DW-1:0] f0,
  input  logic [CHANNELS*8-1:0]  res_filt,
  input  logic [CHANNELS*8-1:0]  mode_vol,
  input  logic [CHANNELS*DW-1:0] voice1,
  input  logic [CHANNELS*DW-1:0] voice2,
  input  logic [CHANNELS*DW-1:0] voice3,
  input  logic [CHANNELS*DW-1:0] ext_in,
  input  logic                   enable,
  input  logic                   mode,
  input  logic [1:0]             mixctl,
  output logic [CHANNELS*DW-1:0] sound,
  output logic                   out_valid
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int IW = 2;
  // Working width: large enough for a full DW x DW product plus headroom.
  localparam int W2 = 2*DW + 2;
  localparam logic signed [W2-1:0] WMAX = {{(W2-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [W2-1:0] WMIN = {{(W2-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] DC   = DW'(DC_OFFSET);

  typedef enum logic [3:0] {
    IDLE, MIX1, MIX2, MIX3, MIX4, SVF1, SVF2, SVF3, SVF4, FSUM, VOL, DONE
  } state_t;

  state_t state, state_next;

  // Sign-extend a sample to the working width.
  function automatic logic signed [W2-1:0] wide(input logic signed [DW-1:0] a);
    return W2'(a);
  endfunction

  // Clamp a working-width value to the signed DW sample range.
  function automatic logic signed [DW-1:0] sat(input logic signed [W2-1:0] x);
    logic signed [DW-1:0] r;
    if (x > WMAX)      r = WMAX[DW-1:0];
    else if (x < WMIN) r = WMIN[DW-1:0];
    else               r = x[DW-1:0];
    return r;
  endfunction

  function automatic logic signed [DW-1:0] sadd(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
    return sat(wide(a) + wide(b));
  endfunction

  function automatic logic signed [DW-1:0] ssub(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
    return sat(wide(a) - wide(b));
  endfunction

  // Resonance to damping factor q, in units of 1/1024.
  function automatic logic [10:0] qtab(input logic [3:0] r);
    logic [10:0] q;
    case (r)
      4'd0:    q = 11'd1433;
      4'd1:    q = 11'd1313;
      4'd2:    q = 11'd1202;
      4'd3:    q = 11'd1104;
      4'd4:    q = 11'd1024;
      4'd5:    q = 11'd938;
      4'd6:    q = 11'd859;
      4'd7:    q = 11'd788;
      4'd8:    q = 11'd716;
      4'd9:    q = 11'd656;
      4'd10:   q = 11'd601;
      4'd11:   q = 11'd552;
      4'd12:   q = 11'd512;
      4'd13:   q = 11'd469;
      4'd14:   q = 11'd429;
      default: q = 11'd394;
    endcase
    return q;
  endfunction

  // Captured frame. Input changes after acceptance do not affect the frame.
  logic signed [DW-1:0] f0_q  [CHANNELS];
  logic signed [DW-1:0] v1_q  [CHANNELS];
  logic signed [DW-1:0] v2_q  [CHANNELS];
  logic signed [DW-1:0] v3_q  [CHANNELS];
  logic signed [DW-1:0] ext_q [CHANNELS];
  logic [7:0]           rf_q  [CHANNELS];
  logic [7:0]           mv_q  [CHANNELS];
  logic                 en_q;
  logic                 mode_q;
  logic [1:0]           mixctl_q;

  // Per-channel integrators, kept from one frame to the next.
  logic signed [DW-1:0] vhp [CHANNELS];
  logic signed [DW-1:0] vbp [CHANNELS];
  logic signed [DW-1:0] vlp [CHANNELS];

  // Working registers for the channel currently being processed.
  logic signed [DW-1:0] vi;
  logic signed [DW-1:0] vnf;
  logic signed [DW-1:0] hp_tmp;
  logic signed [DW-1:0] mix_r;
  logic signed [DW-1:0] stage [CHANNELS];
  logic [CW-1:0]        ch;
  logic [IW-1:0]        iter;

  // Shared multiplier operands and result.
  logic signed [DW-1:0] mul_a;
  logic signed [DW-1:0] mul_b;
  logic signed [W2-1:0] prod;

  // Output-mix terms.
  logic signed [DW-1:0] vf_acc;
  logic signed [DW-1:0] vf_scaled;
  logic signed [DW-1:0] nf_part;
  logic signed [DW-1:0] f_part;
  logic signed [DW-1:0] mix_next;
  logic signed [DW-1:0] vol_res;

  logic [3:0] route;
  logic       v3off;
  logic       last_ch;
  logic       last_iter;

  assign in_ready  = (state == IDLE);
  assign route     = rf_q[ch][3:0];
  assign v3off     = mv_q[ch][7];
  assign last_ch   = (ch == CW'(CHANNELS-1));
  assign last_iter = (iter == IW'(ITERS-1));

  // Capture every input lane when a frame is accepted.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      for (int i = 0; i < CHANNELS; i++) begin
        f0_q[i]  <= f0[i*DW +: DW];
        v1_q[i]  <= voice1[i*DW +: DW];
        v2_q[i]  <= voice2[i*DW +: DW];
        v3_q[i]  <= voice3[i*DW +: DW];
        ext_q[i] <= ext_in[i*DW +: DW];
        rf_q[i]  <= res_filt[i*8 +: 8];
        mv_q[i]  <= mode_vol[i*8 +: 8];
      end
      en_q     <= enable;
      mode_q   <= mode;
      mixctl_q <= mixctl;
    end
  end

  // Only one product is needed per cycle. SVF1/SVF2 scale by w0, SVF3
  // scales by q, and VOL scales by the 4-bit volume.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      SVF1: begin mul_a = vhp[ch]; mul_b = f0_q[ch]; end
      SVF2: begin mul_a = vbp[ch]; mul_b = f0_q[ch]; end
      SVF3: begin mul_a = vbp[ch]; mul_b = DW'(qtab(rf_q[ch][7:4])); end
      VOL:  begin mul_a = mix_r;   mul_b = DW'(mv_q[ch][3:0]); end
      default: ;
    endcase
  end

  assign prod    = wide(mul_a) * wide(mul_b);
  assign vol_res = sat(prod >>> 3);

  // Filter output selection and the two-path mix. These terms are
  // consumed in FSUM, after the final sub-step has updated the integrators.
  always_comb begin
    vf_acc = '0;
    if (mv_q[ch][5]) vf_acc = vbp[ch];
    if (mv_q[ch][4]) vf_acc = sadd(vf_acc, vlp[ch]);
    if (mv_q[ch][6]) vf_acc = sadd(vf_acc, vhp[ch]);
    vf_scaled = mode_q ? vf_acc : ssub(vf_acc, vf_acc >>> 2);
    nf_part   = mixctl_q[1] ? DW'(0) : vnf;
    f_part    = en_q ? (mixctl_q[0] ? DW'(0) : vf_scaled) : vi;
    mix_next  = sadd(nf_part, f_part);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic. The SVF loop repeats ITERS times before FSUM, and the
  // channel loop repeats until the last channel's VOL.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = MIX1;
      MIX1:    state_next = MIX2;
      MIX2:    state_next = MIX3;
      MIX3:    state_next = MIX4;
      MIX4:    state_next = SVF1;
      SVF1:    state_next = SVF2;
      SVF2:    state_next = SVF3;
      SVF3:    state_next = SVF4;
      SVF4:    state_next = last_iter ? FSUM : SVF1;
      FSUM:    state_next = VOL;
      VOL:     state_next = last_ch ? DONE : MIX1;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath. Finished lanes are kept in a staging buffer, so all sound
  // lanes change together in the cycle that out_valid goes high.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        vhp[i]   <= '0;
        vbp[i]   <= '0;
        vlp[i]   <= '0;
        stage[i] <= '0;
      end
      sound     <= '0;
      out_valid <= 1'b0;
      vi        <= '0;
      vnf       <= '0;
      hp_tmp    <= '0;
      mix_r     <= '0;
      ch        <= '0;
      iter      <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          ch   <= '0;
          iter <= '0;
        end
        MIX1: begin
          vi  <= route[0] ? v1_q[ch] : DW'(0);
          vnf <= route[0] ? DC : sadd(DC, v1_q[ch]);
        end
        MIX2: begin
          if (route[1]) vi  <= sadd(vi, v2_q[ch]);
          else          vnf <= sadd(vnf, v2_q[ch]);
        end
        MIX3: begin
          // With v3off set, an unrouted voice 3 is dropped completely.
          if (route[2])    vi  <= sadd(vi, v3_q[ch]);
          else if (!v3off) vnf <= sadd(vnf, v3_q[ch]);
        end
        MIX4: begin
          if (route[3]) vi  <= sadd(vi, ext_q[ch]);
          else          vnf <= sadd(vnf, ext_q[ch]);
        end
        SVF1: vbp[ch] <= sat(wide(vbp[ch]) - (prod >>> (DW+1)));
        SVF2: vlp[ch] <= sat(wide(vlp[ch]) - (prod >>> (DW+1)));
        SVF3: hp_tmp  <= sat((prod >>> 10) - wide(vlp[ch]));
        SVF4: begin
          vhp[ch] <= ssub(hp_tmp, vi);
          iter    <= last_iter ? IW'(0) : iter + IW'(1);
        end
        FSUM: mix_r <= mix_next;
        VOL: begin
          stage[ch] <= vol_res;
          if (last_ch) begin
            out_valid <= 1'b1;
            for (int i = 0; i < CHANNELS; i++)
              sound[i*DW +: DW] <= (CW'(i) == ch) ? vol_res : stage[i];
          end else begin
            ch <= ch + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sid_filters_mc.sv
// ---------------------------------------------------------------------------
// tb_sid_filters_mc
//   Directed bench for sid_filters_mc. Two instances share the same inputs:
//   u_dut (ITERS=1) and u_dut2 (ITERS=2). A vector table drives identical
//   inputs on both lanes. Hand-written sequences then cover lane independence
//   with a low-pass step, a reset mid-frame, and back-to-back frames.
// ---------------------------------------------------------------------------
module tb_sid_filters_mc;

  localparam int CH = 2;
  localparam int DW = 18;
  localparam int LAT1 = CH*(6+4*1)+1;
  localparam int LAT2 = CH*(6+4*2)+1;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic in_ready, in_ready2;
  logic [CH*DW-1:0] f0, voice1, voice2, voice3, ext_in;
  logic [CH*8-1:0]  res_filt, mode_vol;
  logic enable, mode;
  logic [1:0] mixctl;
  logic [CH*DW-1:0] sound, sound2;
  logic out_valid, out_valid2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sid_filters_mc #(.CHANNELS(CH), .DW(DW), .ITERS(1), .DC_OFFSET(16384)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .f0(f0), .res_filt(res_filt), .mode_vol(mode_vol),
    .voice1(voice1), .voice2(voice2), .voice3(voice3), .ext_in(ext_in),
    .enable(enable), .mode(mode), .mixctl(mixctl),
    .sound(sound), .out_valid(out_valid)
  );

  sid_filters_mc #(.CHANNELS(CH), .DW(DW), .ITERS(2), .DC_OFFSET(16384)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .f0(f0), .res_filt(res_filt), .mode_vol(mode_vol),
    .voice1(voice1), .voice2(voice2), .voice3(voice3), .ext_in(ext_in),
    .enable(enable), .mode(mode), .mixctl(mixctl),
    .sound(sound2), .out_valid(out_valid2)
  );

  typedef struct {
    bit         do_rst;
    logic [7:0] rf;
    logic [7:0] mv;
    int         v1, v2, v3, ex;
    bit         en, md;
    logic [1:0] mx;
    int         e1, e2;
  } vec_t;

  vec_t vt[16];
  int   lp_exp[4] = '{0, -8, -25, -49};

  function automatic int lane(input logic [CH*DW-1:0] bus, input int i);
    logic signed [DW-1:0] v;
    v = bus[i*DW +: DW];
    return int'(v);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    f0       = {DW'(8000), DW'(8000)};
    res_filt = {v.rf, v.rf};
    mode_vol = {v.mv, v.mv};
    voice1   = {DW'(v.v1), DW'(v.v1)};
    voice2   = {DW'(v.v2), DW'(v.v2)};
    voice3   = {DW'(v.v3), DW'(v.v3)};
    ext_in   = {DW'(v.ex), DW'(v.ex)};
    enable   = v.en;
    mode     = v.md;
    mixctl   = v.mx;
  endtask

  task automatic doReset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  // Pulse in_valid for one cycle, scramble the sample inputs right after
  // acceptance, then wait (bounded) for each instance's out_valid.
  task automatic runFrame(output int lat1, output int lat2);
    int n;
    lat1 = -1;
    lat2 = -1;
    @(negedge clk) in_valid = 1'b1;
    @(negedge clk) in_valid = 1'b0;
    voice1 = (CH*DW)'({$urandom(), $urandom()});
    voice2 = (CH*DW)'({$urandom(), $urandom()});
    voice3 = (CH*DW)'({$urandom(), $urandom()});
    ext_in = (CH*DW)'({$urandom(), $urandom()});
    n = 1;
    while ((lat1 < 0 || lat2 < 0) && n < 100) begin
      if (out_valid  && lat1 < 0) lat1 = n;
      if (out_valid2 && lat2 < 0) lat2 = n;
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int lat1, lat2, n, pulses, found;
    int t[3];

    //            rst   rf     mv     v1      v2      v3      ex      en    md    mx     e1       e2
    vt[0]  = '{1'b1, 8'h00, 8'h0F,   1000,   1000,   1000,      0, 1'b1, 1'b1, 2'b00,  36345,  36345};
    vt[1]  = '{1'b0, 8'h00, 8'h0F, 131071, 131071, 131071, 131071, 1'b1, 1'b1, 2'b00, 131071, 131071};
    vt[2]  = '{1'b0, 8'h00, 8'h0F,-131072,-131072,-131072,-131072, 1'b1, 1'b1, 2'b00,-131072,-131072};
    vt[3]  = '{1'b0, 8'h00, 8'h00,   1000,   1000,   1000,      0, 1'b1, 1'b1, 2'b00,      0,      0};
    vt[4]  = '{1'b0, 8'h00, 8'h01,   1000,   1000,   1000,      0, 1'b1, 1'b1, 2'b00,   2423,   2423};
    vt[5]  = '{1'b0, 8'h01, 8'h0F,   1000,   1000,   1000,      0, 1'b0, 1'b1, 2'b10,   1875,   1875};
    vt[6]  = '{1'b0, 8'h01, 8'h0F,   1000,   1000,   1000,      0, 1'b0, 1'b1, 2'b01,  36345,  36345};
    vt[7]  = '{1'b0, 8'h01, 8'h0F,   1000,   1000,   1000,      0, 1'b1, 1'b1, 2'b11,      0,      0};
    vt[8]  = '{1'b0, 8'h00, 8'h0F, -10000, -10000, -10000, -10000, 1'b1, 1'b1, 2'b00, -44280, -44280};
    vt[9]  = '{1'b1, 8'h01, 8'h4F,   8000,      0,      0,      0, 1'b1, 1'b1, 2'b10, -15000, -14676};
    vt[10] = '{1'b1, 8'h01, 8'h4F,   8000,      0,      0,      0, 1'b1, 1'b0, 2'b10, -11250, -11007};
    vt[11] = '{1'b0, 8'h00, 8'h8F,   1000,   1000,   5000,      0, 1'b1, 1'b1, 2'b00,  34470,  34470};
    vt[12] = '{1'b0, 8'h00, 8'h0F,   1000,   1000,   5000,      0, 1'b1, 1'b1, 2'b00,  43845,  43845};
    vt[13] = '{1'b0, 8'h04, 8'h8F,   1000,   1000,   5000,      0, 1'b0, 1'b1, 2'b00,  43845,  43845};
    vt[14] = '{1'b0, 8'h08, 8'h0F,      0,      0,      0,   2000, 1'b0, 1'b1, 2'b10,   3750,   3750};
    vt[15] = '{1'b0, 8'h00, 8'h0F,      0,      0,      0,   2000, 1'b1, 1'b1, 2'b00,  34470,  34470};

    rst = 1'b1;
    in_valid = 1'b0;
    applyStimulus(vt[0]);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    checkOutput("reset in_ready", int'(in_ready), 1);
    checkOutput("reset out_valid", int'(out_valid), 0);
    checkOutput("reset sound lane0", lane(sound, 0), 0);
    checkOutput("reset sound lane1", lane(sound, 1), 0);

    // Vector table
    for (int i = 0; i < 16; i++) begin
      if (vt[i].do_rst) doReset();
      applyStimulus(vt[i]);
      runFrame(lat1, lat2);
      checkOutput($sformatf("vec%0d latency", i), lat1, LAT1);
      checkOutput($sformatf("vec%0d latency iters2", i), lat2, LAT2);
      checkOutput($sformatf("vec%0d lane0", i), lane(sound, 0), vt[i].e1);
      checkOutput($sformatf("vec%0d lane1", i), lane(sound, 1), vt[i].e1);
      checkOutput($sformatf("vec%0d iters2 lane0", i), lane(sound2, 0), vt[i].e2);
      checkOutput($sformatf("vec%0d iters2 lane1", i), lane(sound2, 1), vt[i].e2);
      checkOutput($sformatf("vec%0d in_ready", i), int'(in_ready), 1);
    end

    // Low-pass step on lane 0 only; lane 1 idle with the unfiltered path muted
    doReset();
    for (int k = 0; k < 4; k++) begin
      f0       = {DW'(0), DW'(8000)};
      res_filt = {8'h00, 8'h01};
      mode_vol = {8'h0F, 8'h1F};
      voice1   = {DW'(0), DW'(20000)};
      voice2   = '0;
      voice3   = '0;
      ext_in   = '0;
      enable   = 1'b1;
      mode     = 1'b1;
      mixctl   = 2'b10;
      runFrame(lat1, lat2);
      checkOutput($sformatf("lp frame%0d latency", k), lat1, LAT1);
      checkOutput($sformatf("lp frame%0d lane0", k), lane(sound, 0), lp_exp[k]);
      checkOutput($sformatf("lp frame%0d lane1", k), lane(sound, 1), 0);
    end

    // Reset mid-frame: nothing emitted, outputs and integrators cleared
    applyStimulus(vt[0]);
    @(negedge clk) in_valid = 1'b1;
    @(negedge clk) in_valid = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("busy in_ready", int'(in_ready), 0);
    doReset();
    checkOutput("midreset in_ready", int'(in_ready), 1);
    checkOutput("midreset sound lane0", lane(sound, 0), 0);
    checkOutput("midreset sound lane1", lane(sound, 1), 0);
    checkOutput("midreset iters2 lane0", lane(sound2, 0), 0);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid || out_valid2) pulses++;
    end
    checkOutput("midreset out_valid pulses", pulses, 0);
    applyStimulus(vt[9]);
    runFrame(lat1, lat2);
    checkOutput("post-reset hp lane0", lane(sound, 0), -15000);
    checkOutput("post-reset hp iters2 lane0", lane(sound2, 0), -14676);

    // in_valid held high: frames accepted only when idle
    applyStimulus(vt[0]);
    t[0] = -1000; t[1] = -1000; t[2] = -1000;
    @(negedge clk) in_valid = 1'b1;
    found = 0;
    n = 0;
    while (found < 3 && n < 100) begin
      @(negedge clk);
      n++;
      if (out_valid) begin
        t[found] = n;
        found++;
      end
    end
    checkOutput("flow first latency", t[0], LAT1);
    checkOutput("flow spacing 1", t[1] - t[0], LAT1 + 1);
    checkOutput("flow spacing 2", t[2] - t[1], LAT1 + 1);
    checkOutput("flow lane0", lane(sound, 0), 36345);
    in_valid = 1'b0;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
